bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one byte-enabled single-port data/instruction BRAM between two requesters: instruction fetch (read-only) and load/store unit.
- Performs RV32I sub-word store lane steering and byte-enable generation, load extraction and sign/zero extension, and misalignment detection.
- Sits between the core pipeline and the BRAM. Issues at most one memory access per cycle. Every response arrives exactly one cycle after its grant.

Parameters:
- DEPTH, 4096, BRAM depth; sets address width AW = $clog2(DEPTH).
- XLEN, 32, data width; fixed at 32 for byte-lane logic.
- MAX_DSTREAK, 4, consecutive contested data grants before the fetch port is forced one slot (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  AW  fetch byte address.
- if_req_ready  out  1  fetch request granted this cycle.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  32  fetched word.
- if_rsp_err  out  1  fetch address not word-aligned.
- ls_req_valid  in  1  load/store request.
- ls_req_we  in  1  1 = store, 0 = load.
- ls_req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- ls_req_addr  in  AW  byte address.
- ls_req_wdata  in  32  store data, right-aligned.
- ls_req_ready  out  1  load/store request granted this cycle.
- ls_rsp_valid  out  1  load data, or store completion.
- ls_rsp_data  out  32  extended load result; 0 for stores.
- ls_rsp_err  out  1  misaligned access or illegal funct3.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  AW  BRAM byte address; low 2 bits forced to 0.
- mem_wdata  out  32  lane-steered store data.
- mem_byte_we  out  4  per-byte write strobe.
- mem_rdata  in  32  BRAM read word, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, streak counter 0, pending-response tracker cleared. A response in flight when reset asserts is dropped; no rsp_valid after release.
- Request interface:
  - mem_* outputs are combinational from the winning request. The BRAM registers the address on the same edge the grant occurs.
  - ready is combinational from valid and the arbitration state.
  - A request is consumed on a cycle where valid && ready; otherwise the requester holds it.
- Arbitration:
  - Only fetch valid: fetch wins. Only ls valid: ls wins.
  - Both valid: ls wins and the streak counter increments. When the counter equals MAX_DSTREAK, fetch wins instead and the counter clears.
  - Counter also clears on any cycle fetch wins, and on any cycle ls is idle.
- Alignment and illegal codes:
  - Fetch with addr[1:0]!=0: granted but no mem_en; if_rsp_err=1 next cycle, data 0.
  - ls misaligned (H with addr[0]=1, W with addr[1:0]!=0) or undefined funct3: granted but no mem_en; ls_rsp_err=1 next cycle, data 0.
- Store path: mem_we=1.
  - SB: byte_we = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: byte_we = 0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: byte_we = 1111.
- Pending tracker FSM: states IDLE, IF_PEND, LS_LD_PEND, LS_ST_PEND, ERR_PEND(port).
  - Next state is set by this cycle's grant; with no grant it returns to IDLE.
  - Back-to-back grants are allowed every cycle.
  - Registered offset addr[1:0] and funct3 are captured with the grant.
- Response timing and data, one cycle after grant:
  - rsp_valid pulses for exactly one cycle.
  - Loads: select the byte/half from mem_rdata using the registered offset. Sign-extend for B/H, zero-extend for BU/HU.
  - Stores: ls_rsp_valid=1 with data 0.
- Simultaneous events: exactly one port is granted per cycle; the losing port's ready stays 0. No response is ever lost or duplicated.

Test Plan:
- After reset, fetch 0x10 with mem word[4]=0xDEADBEEF -> if_req_ready same cycle; next cycle if_rsp_valid=1, data 0xDEADBEEF, err 0.
- Store SB 0xA5 to addr 0x21, then LB from 0x21 -> mem_byte_we=0010, mem_wdata=0xA5A5A5A5; load returns 0xFFFFFFA5. LBU from the same address returns 0x000000A5.
- SH 0x8001 to 0x42, then LH from 0x42 -> byte_we=1100; load returns 0xFFFF8001. SW to 0x43 -> ls_rsp_err=1, mem_en never asserted.
- Both ports valid continuously for 12 cycles, MAX_DSTREAK=4 -> grant pattern LS,LS,LS,LS,IF repeated; every grant yields exactly one rsp.
- rst_n asserted in the cycle after an LW grant -> all outputs 0 immediately; no ls_rsp_valid after release; first new fetch is served normally.
- Fetch at 0x6 -> if_rsp_err=1, no BRAM access; a subsequent fetch at 0x8 succeeds back-to-back.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter_if
// Bundles the fetch port, the load/store port and the BRAM port of the
// bram_port_arbiter into one interface.
//   slave  : the arbiter side. It takes requests and mem_rdata, and it drives
//            ready, the responses and the mem_* controls.
//   master : the core/BRAM side, with the directions reversed.
// Handshake rules:
//   - A request is consumed on a cycle where *_req_valid && *_req_ready.
//   - Until then the requester holds the request unchanged.
//   - ready is combinational from valid and the arbitration state.
//   - *_rsp_valid is a single-cycle pulse, one cycle after the grant.
// ---------------------------------------------------------------------------
interface bram_port_arbiter_if #(
   parameter int AW = 12
);
   // fetch port
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_rsp_valid;
   logic [31:0]   if_rsp_data;
   logic          if_rsp_err;
   // load/store port
   logic          ls_req_valid;
   logic          ls_req_we;
   logic [2:0]    ls_req_funct3;
   logic [AW-1:0] ls_req_addr;
   logic [31:0]   ls_req_wdata;
   logic          ls_req_ready;
   logic          ls_rsp_valid;
   logic [31:0]   ls_rsp_data;
   logic          ls_rsp_err;
   // BRAM port
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_byte_we;
   logic [31:0]   mem_rdata;

   modport slave (
      input  if_req_valid, if_req_addr,
      input  ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_byte_we
   );

   modport master (
      output if_req_valid, if_req_addr,
      output ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_byte_we
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
// Shares one single-port, byte-enabled BRAM between an instruction fetch port
// (read-only) and a load/store port. The arbiter grants at most one access
// per cycle.
//   - It steers RV32I sub-word store data onto the byte lanes and generates
//     the byte write strobes.
//   - It extracts and sign- or zero-extends load results.
//   - It flags misaligned accesses and undefined funct3 codes.
// Every response appears exactly one cycle after its grant.
// Ports:
//   clk         : clock. All state updates on posedge.
//   rst_n       : asynchronous active-low reset.
//   bus         : request, response and BRAM signals (slave modport).
//   o_dbg_state : current state of the pending-response tracker.
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int DEPTH       = 4096,
   parameter int XLEN        = 32,
   parameter int MAX_DSTREAK = 4,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   bram_port_arbiter_if.slave  bus,
   output logic [2:0]          o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_IF_PEND     = 3'd1,
      ST_LS_LD_PEND  = 3'd2,
      ST_LS_ST_PEND  = 3'd3,
      ST_IF_ERR_PEND = 3'd4,
      ST_LS_ERR_PEND = 3'd5
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_DSTREAK);

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_streak;
   logic [1:0]      r_off;
   logic [2:0]      r_funct3;

   logic            w_both, w_force_if, w_grant_if, w_grant_ls;
   logic            w_if_ok, w_ls_ok;
   logic [3:0]      w_st_be;
   logic [XLEN-1:0] w_st_data;
   logic [7:0]      w_ld_byte;
   logic [15:0]     w_ld_half;
   logic [XLEN-1:0] w_ld_word;

   // ---------------- arbitration ----------------
   // While both ports are valid, ls wins until the streak reaches the limit.
   // At the limit fetch takes one slot.
   // Both grants are gated with rst_n, so nothing is granted during reset.
   assign w_both     = bus.if_req_valid & bus.ls_req_valid;
   assign w_force_if = w_both & (r_streak == LP_MAX);
   assign w_grant_if = rst_n & bus.if_req_valid & (~bus.ls_req_valid | w_force_if);
   assign w_grant_ls = rst_n & bus.ls_req_valid & ~w_force_if;

   assign bus.if_req_ready = w_grant_if;
   assign bus.ls_req_ready = w_grant_ls;

   // ---------------- legality ----------------
   assign w_if_ok = (bus.if_req_addr[1:0] == 2'b00);

   always_comb begin
      w_ls_ok = 1'b0;
      case (bus.ls_req_funct3)
         3'b000:  w_ls_ok = 1'b1;
         3'b001:  w_ls_ok = ~bus.ls_req_addr[0];
         3'b010:  w_ls_ok = (bus.ls_req_addr[1:0] == 2'b00);
         // Unsigned widths exist for loads only.
         3'b100:  w_ls_ok = ~bus.ls_req_we;
         3'b101:  w_ls_ok = ~bus.ls_req_we & ~bus.ls_req_addr[0];
         default: w_ls_ok = 1'b0;
      endcase
   end

   // ---------------- store lane steering ----------------
   always_comb begin
      w_st_be   = 4'b1111;
      w_st_data = bus.ls_req_wdata;
      case (bus.ls_req_funct3[1:0])
         2'b00: begin
            w_st_be   = 4'b0001 << bus.ls_req_addr[1:0];
            w_st_data = {4{bus.ls_req_wdata[7:0]}};
         end
         2'b01: begin
            w_st_be   = 4'b0011 << bus.ls_req_addr[1:0];
            w_st_data = {2{bus.ls_req_wdata[15:0]}};
         end
         default: begin
            w_st_be   = 4'b1111;
            w_st_data = bus.ls_req_wdata;
         end
      endcase
   end

   // ---------------- BRAM controls ----------------
   // A rejected access (misaligned or illegal) is granted, but the BRAM is
   // never touched for it.
   always_comb begin
      bus.mem_en      = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.mem_byte_we = 4'b0000;
      if (w_grant_if && w_if_ok) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = {bus.if_req_addr[AW-1:2], 2'b00};
      end else if (w_grant_ls && w_ls_ok) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.ls_req_we;
         bus.mem_addr = {bus.ls_req_addr[AW-1:2], 2'b00};
         if (bus.ls_req_we) begin
            bus.mem_wdata   = w_st_data;
            bus.mem_byte_we = w_st_be;
         end
      end
   end

   // ---------------- pending-response tracker ----------------
   always_comb begin
      w_state_nxt = ST_IDLE;
      if (w_grant_if)
         w_state_nxt = w_if_ok ? ST_IF_PEND : ST_IF_ERR_PEND;
      else if (w_grant_ls)
         w_state_nxt = !w_ls_ok      ? ST_LS_ERR_PEND :
                       bus.ls_req_we ? ST_LS_ST_PEND  : ST_LS_LD_PEND;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_streak <= 4'd0;
         r_off    <= 2'b00;
         r_funct3 <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         // The streak only grows on ls grants that beat a waiting fetch.
         if (w_grant_ls && w_both)
            r_streak <= r_streak + 4'd1;
         else
            r_streak <= 4'd0;
         if (w_grant_ls) begin
            r_off    <= bus.ls_req_addr[1:0];
            r_funct3 <= bus.ls_req_funct3;
         end
      end
   end

   assign o_dbg_state = r_state;

   // ---------------- load extraction ----------------
   always_comb begin
      w_ld_byte = bus.mem_rdata[7:0];
      case (r_off)
         2'd0: w_ld_byte = bus.mem_rdata[7:0];
         2'd1: w_ld_byte = bus.mem_rdata[15:8];
         2'd2: w_ld_byte = bus.mem_rdata[23:16];
         2'd3: w_ld_byte = bus.mem_rdata[31:24];
         default: w_ld_byte = bus.mem_rdata[7:0];
      endcase
      w_ld_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_word = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_word = {{16{w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_word = {24'd0, w_ld_byte};
         3'b101:  w_ld_word = {16'd0, w_ld_half};
         default: w_ld_word = bus.mem_rdata;
      endcase
   end

   // ---------------- responses ----------------
   // Responses decode the tracker state, so reset clears them at once.
   assign bus.if_rsp_valid = (r_state == ST_IF_PEND) | (r_state == ST_IF_ERR_PEND);
   assign bus.if_rsp_err   = (r_state == ST_IF_ERR_PEND);
   assign bus.if_rsp_data  = (r_state == ST_IF_PEND) ? bus.mem_rdata : 32'd0;

   assign bus.ls_rsp_valid = (r_state == ST_LS_LD_PEND) | (r_state == ST_LS_ST_PEND) |
                             (r_state == ST_LS_ERR_PEND);
   assign bus.ls_rsp_err   = (r_state == ST_LS_ERR_PEND);
   assign bus.ls_rsp_data  = (r_state == ST_LS_LD_PEND) ? w_ld_word : 32'd0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter. A behavioural BRAM answers mem_en
// reads one cycle later and applies byte-enabled writes.
// Timing:
//   - Inputs change 1 ns after posedge.
//   - Combinational outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

   localparam int AW = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   bram_port_arbiter_if #(.AW(AW)) bus ();

   bram_port_arbiter #(.DEPTH(4096), .XLEN(32), .MAX_DSTREAK(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural BRAM ----------------
   logic [31:0] mem_arr [0:1023];
   logic        mem_clear, preload_en;
   logic [9:0]  preload_idx;
   logic [31:0] preload_val;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int k = 0; k < 1024; k++) mem_arr[k] <= 32'd0;
         bus.mem_rdata <= 32'd0;
      end else if (preload_en) begin
         mem_arr[preload_idx] <= preload_val;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_byte_we[b]) mem_arr[bus.mem_addr[11:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end else begin
            bus.mem_rdata <= mem_arr[bus.mem_addr[11:2]];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req_valid  = 1'b0;
      bus.if_req_addr   = '0;
      bus.ls_req_valid  = 1'b0;
      bus.ls_req_we     = 1'b0;
      bus.ls_req_funct3 = 3'b000;
      bus.ls_req_addr   = '0;
      bus.ls_req_wdata  = 32'd0;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      preload_idx = idx;
      preload_val = val;
      preload_en  = 1'b1;
      tick();
      preload_en  = 1'b0;
   endtask

   task automatic drive_fetch(input logic [AW-1:0] addr);
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = addr;
   endtask

   task automatic drive_ls(input logic we, input logic [2:0] f3,
                           input logic [AW-1:0] addr, input logic [31:0] wd);
      bus.ls_req_valid  = 1'b1;
      bus.ls_req_we     = we;
      bus.ls_req_funct3 = f3;
      bus.ls_req_addr   = addr;
      bus.ls_req_wdata  = wd;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive_fetch(12'h010);
      drive_ls(1'b0, 3'b010, 12'h020, 32'd0);
      #1;
      n_checks++; if (bus.if_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b exp 0", bus.if_req_ready); end
      n_checks++; if (bus.ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ls_ready: got %b exp 0", bus.ls_req_ready); end
      n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b exp 0", bus.mem_en); end
      n_checks++; if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 00", {bus.if_rsp_valid, bus.ls_rsp_valid}); end
      n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      preload(10'd4, 32'hDEADBEEF);
      drive_fetch(12'h010);
      #1;
      n_checks++; if (bus.if_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready: got %b exp 1", bus.if_req_ready); end
      n_checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'h010}) begin n_fail++; $display("FAIL fetch_mem: got en=%b we=%b addr=%h exp 1 0 010", bus.mem_en, bus.mem_we, bus.mem_addr); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL fetch_rsp: got v=%b e=%b d=%h exp 1 0 deadbeef", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
      tick();
      n_checks++; if (bus.if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_rsp_pulse: got %b exp 0", bus.if_rsp_valid); end
   endtask

   task automatic test_byte();
      drive_ls(1'b1, 3'b000, 12'h021, 32'h000000A5);
      #1;
      n_checks++; if ({bus.ls_req_ready, bus.mem_en, bus.mem_we, bus.mem_byte_we} !== 7'b1110010) begin n_fail++; $display("FAIL sb_ctrl: got rdy=%b en=%b we=%b be=%b exp 1 1 1 0010", bus.ls_req_ready, bus.mem_en, bus.mem_we, bus.mem_byte_we); end
      n_checks++; if (bus.mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", bus.mem_wdata); end
      tick();
      drive_ls(1'b0, 3'b000, 12'h021, 32'd0);
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data} !== {1'b1, 1'b0, 32'd0}) begin n_fail++; $display("FAIL sb_rsp: got v=%b e=%b d=%h exp 1 0 0", bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data); end
      n_checks++; if ({bus.ls_req_ready, bus.mem_en, bus.mem_we} !== 3'b110) begin n_fail++; $display("FAIL lb_ctrl: got rdy=%b en=%b we=%b exp 1 1 0", bus.ls_req_ready, bus.mem_en, bus.mem_we); end
      tick();
      drive_ls(1'b0, 3'b100, 12'h021, 32'd0);
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'hFFFFFFA5}) begin n_fail++; $display("FAIL lb_rsp: got v=%b d=%h exp 1 ffffffa5", bus.ls_rsp_valid, bus.ls_rsp_data); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'h000000A5}) begin n_fail++; $display("FAIL lbu_rsp: got v=%b d=%h exp 1 000000a5", bus.ls_rsp_valid, bus.ls_rsp_data); end
      tick();
   endtask

   task automatic test_half();
      drive_ls(1'b1, 3'b001, 12'h042, 32'h00008001);
      #1;
      n_checks++; if ({bus.mem_en, bus.mem_we, bus.mem_byte_we, bus.mem_addr} !== {1'b1, 1'b1, 4'b1100, 12'h040}) begin n_fail++; $display("FAIL sh_ctrl: got en=%b we=%b be=%b addr=%h exp 1 1 1100 040", bus.mem_en, bus.mem_we, bus.mem_byte_we, bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 32'h80018001) begin n_fail++; $display("FAIL sh_wdata: got %h exp 80018001", bus.mem_wdata); end
      tick();
      drive_ls(1'b0, 3'b001, 12'h042, 32'd0);
      tick();
      drive_ls(1'b1, 3'b010, 12'h043, 32'h12345678);
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'hFFFF8001}) begin n_fail++; $display("FAIL lh_rsp: got v=%b d=%h exp 1 ffff8001", bus.ls_rsp_valid, bus.ls_rsp_data); end
      n_checks++; if ({bus.ls_req_ready, bus.mem_en} !== 2'b10) begin n_fail++; $display("FAIL sw_misal_ctrl: got rdy=%b en=%b exp 1 0", bus.ls_req_ready, bus.mem_en); end
      tick();
      drive_ls(1'b0, 3'b011, 12'h040, 32'd0);
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data} !== {1'b1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL sw_misal_rsp: got v=%b e=%b d=%h exp 1 1 0", bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data); end
      n_checks++; if ({bus.ls_req_ready, bus.mem_en} !== 2'b10) begin n_fail++; $display("FAIL illegal_f3_ctrl: got rdy=%b en=%b exp 1 0", bus.ls_req_ready, bus.mem_en); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_err} !== 2'b11) begin n_fail++; $display("FAIL illegal_f3_rsp: got v=%b e=%b exp 1 1", bus.ls_rsp_valid, bus.ls_rsp_err); end
      tick();
   endtask

   task automatic test_arbitration();
      logic [11:0] exp_ls;
      logic        prev_ls;
      exp_ls    = '1;
      exp_ls[4] = 1'b0;
      exp_ls[9] = 1'b0;
      prev_ls   = 1'b0;
      drive_fetch(12'h010);
      drive_ls(1'b0, 3'b010, 12'h020, 32'd0);
      for (int i = 0; i < 12; i++) begin
         #1;
         n_checks++; if ({bus.ls_req_ready, bus.if_req_ready} !== {exp_ls[i], ~exp_ls[i]}) begin n_fail++; $display("FAIL arb_grant[%0d]: got ls=%b if=%b exp ls=%b", i, bus.ls_req_ready, bus.if_req_ready, exp_ls[i]); end
         if (i > 0) begin
            n_checks++;
            if ({bus.ls_rsp_valid, bus.if_rsp_valid} !== {prev_ls, ~prev_ls} ||
                (prev_ls ? bus.ls_rsp_data !== 32'h0000A500 : bus.if_rsp_data !== 32'hDEADBEEF)) begin
               n_fail++;
               $display("FAIL arb_rsp[%0d]: got lsv=%b ifv=%b lsd=%h ifd=%h exp ls=%b", i, bus.ls_rsp_valid, bus.if_rsp_valid, bus.ls_rsp_data, bus.if_rsp_data, prev_ls);
            end
         end
         prev_ls = exp_ls[i];
         @(posedge clk);
         #1;
      end
      idle_inputs();
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.if_rsp_valid, bus.ls_rsp_data} !== {2'b10, 32'h0000A500}) begin n_fail++; $display("FAIL arb_last_rsp: got lsv=%b ifv=%b d=%h exp 1 0 0000a500", bus.ls_rsp_valid, bus.if_rsp_valid, bus.ls_rsp_data); end
      tick();
      n_checks++; if ({bus.ls_rsp_valid, bus.if_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL arb_no_extra_rsp: got %b exp 00", {bus.ls_rsp_valid, bus.if_rsp_valid}); end
   endtask

   task automatic test_reset_inflight();
      drive_ls(1'b0, 3'b010, 12'h020, 32'd0);
      #1;
      n_checks++; if (bus.ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lw_ready: got %b exp 1", bus.ls_req_ready); end
      tick();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      n_checks++; if ({bus.ls_rsp_valid, bus.ls_rsp_data, bus.mem_en, dbg_state} !== {1'b0, 32'd0, 1'b0, 3'd0}) begin n_fail++; $display("FAIL rst_inflight_outputs: got v=%b d=%h en=%b st=%0d exp 0 0 0 0", bus.ls_rsp_valid, bus.ls_rsp_data, bus.mem_en, dbg_state); end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if ({bus.ls_rsp_valid, bus.if_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_dropped_rsp: got %b exp 00", {bus.ls_rsp_valid, bus.if_rsp_valid}); end
      drive_fetch(12'h010);
      #1;
      n_checks++; if ({bus.if_req_ready, bus.mem_en} !== 2'b11) begin n_fail++; $display("FAIL rst_fetch_grant: got rdy=%b en=%b exp 1 1", bus.if_req_ready, bus.mem_en); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_data, bus.ls_rsp_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin n_fail++; $display("FAIL rst_fetch_rsp: got v=%b d=%h lsv=%b exp 1 deadbeef 0", bus.if_rsp_valid, bus.if_rsp_data, bus.ls_rsp_valid); end
      tick();
   endtask

   task automatic test_misaligned_fetch();
      preload(10'd2, 32'h12345678);
      drive_fetch(12'h006);
      #1;
      n_checks++; if ({bus.if_req_ready, bus.mem_en} !== 2'b10) begin n_fail++; $display("FAIL if_misal_ctrl: got rdy=%b en=%b exp 1 0", bus.if_req_ready, bus.mem_en); end
      tick();
      drive_fetch(12'h008);
      #1;
      n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {1'b1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL if_misal_rsp: got v=%b e=%b d=%h exp 1 1 0", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
      n_checks++; if ({bus.if_req_ready, bus.mem_en, bus.mem_addr} !== {2'b11, 12'h008}) begin n_fail++; $display("FAIL if_b2b_ctrl: got rdy=%b en=%b addr=%h exp 1 1 008", bus.if_req_ready, bus.mem_en, bus.mem_addr); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {1'b1, 1'b0, 32'h12345678}) begin n_fail++; $display("FAIL if_b2b_rsp: got v=%b e=%b d=%h exp 1 0 12345678", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
      tick();
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n       = 1'b0;
      mem_clear   = 1'b1;
      preload_en  = 1'b0;
      preload_idx = '0;
      preload_val = '0;
      idle_inputs();
      tick();
      tick();
      mem_clear = 1'b0;
      test_reset();
      test_fetch();
      test_byte();
      test_half();
      test_arbitration();
      test_reset_inflight();
      test_misaligned_fetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
